// File: rtl/dm_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dm_arbiter_if
//  Purpose  : Bundle of the two requester ports and the data-memory pins
//             shared by dm_arbiter and whatever drives/observes it.
//  Revision : 1.0  initial release
// ============================================================================
interface dm_arbiter_if #(
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [31:0]   m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic          m0_err;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [31:0]   m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic          m1_err;
  logic [DW-1:0] m1_rdata;

  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  logic [1:0]    grant;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m0_err, m0_rdata,
    output m1_ack, m1_err, m1_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    output grant
  );

  // Requesters plus memory side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m0_err, m0_rdata,
    input  m1_ack, m1_err, m1_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    input  grant
  );
endinterface
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dm_arbiter
//  Purpose  : Two-port round-robin arbiter and IDLE/ACCESS/RESP sequencer in
//             front of a single-port word-addressed data memory.
//  Revision : 1.0  initial release
// ============================================================================
module dm_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;          // 1 = m1 was granted last
  logic [1:0]    grant_q, grant_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m0_err_q, m0_err_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic          m1_ack_q, m1_ack_d;
  logic          m1_err_q, m1_err_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

  logic          w_in_range;
  logic          w_win1;

  assign w_in_range = ((addr_q >> AW) == 32'd0);
  // m1 wins when alone, or on a tie when m0 was granted last
  assign w_win1     = bus.m1_req & (~bus.m0_req | ~ptr_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b1;
      grant_q    <= 2'b00;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= '0;
      m0_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_ack_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_ack_q   <= m0_ack_d;
      m0_err_q   <= m0_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_ack_q   <= m1_ack_d;
      m1_err_q   <= m1_err_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_ack_d   = 1'b0;
    m0_err_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_ack_d   = 1'b0;
    m1_err_d   = 1'b0;
    m1_rdata_d = m1_rdata_q;
    bus.mem_we = 1'b0;
    bus.mem_re = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d = ACCESS;
          ptr_d   = w_win1;
          grant_d = w_win1 ? 2'b10 : 2'b01;
          we_d    = w_win1 ? bus.m1_we    : bus.m0_we;
          addr_d  = w_win1 ? bus.m1_addr  : bus.m0_addr;
          wdata_d = w_win1 ? bus.m1_wdata : bus.m0_wdata;
        end
      end

      ACCESS: begin
        state_d    = RESP;
        bus.mem_we = we_q & w_in_range;
        bus.mem_re = ~we_q & w_in_range;
        if (grant_q[0]) begin
          m0_ack_d = 1'b1;
          m0_err_d = ~w_in_range;
          if (!w_in_range)
            m0_rdata_d = '0;
          else if (!we_q)
            m0_rdata_d = bus.mem_rdata;
        end
        if (grant_q[1]) begin
          m1_ack_d = 1'b1;
          m1_err_d = ~w_in_range;
          if (!w_in_range)
            m1_rdata_d = '0;
          else if (!we_q)
            m1_rdata_d = bus.mem_rdata;
        end
      end

      RESP: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end

      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.grant     = grant_q;
  assign bus.m0_ack    = m0_ack_q;
  assign bus.m0_err    = m0_err_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_ack    = m1_ack_q;
  assign bus.m1_err    = m1_err_q;
  assign bus.m1_rdata  = m1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_arbiter
//  Purpose  : Self-checking bench for dm_arbiter with a behavioural data memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dm_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam logic [31:0] D = 32'hDEADBEEF;

  typedef logic [127:0] word_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_arbiter_if #(.DW(DW)) bus ();
  dm_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [DW-1:0] dmem [0:(1<<AW)-1];
  logic          w_mem_in;
  assign w_mem_in      = ((bus.mem_addr >> AW) == 32'd0);
  assign bus.mem_rdata = w_mem_in ? dmem[bus.mem_addr[AW-1:0]] : 32'hBAD0BAD0;
  always @(posedge clk)
    if (bus.mem_we && w_mem_in) dmem[bus.mem_addr[AW-1:0]] <= bus.mem_wdata;

  typedef struct {
    logic          r0, w0;
    logic [31:0]   a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [31:0]   a1;
    logic [DW-1:0] d1;
    logic [1:0]    eg;
    logic          ewe, ere;
    logic          ea0, ee0;
    logic [DW-1:0] erd0;
    logic          ea1, ee1;
    logic [DW-1:0] erd1;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    input logic r0, w0, input logic [31:0] a0, input logic [DW-1:0] d0,
    input logic r1, w1, input logic [31:0] a1, input logic [DW-1:0] d1,
    input logic [1:0] eg, input logic ewe, ere,
    input logic ea0, ee0, input logic [DW-1:0] erd0,
    input logic ea1, ee1, input logic [DW-1:0] erd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg = eg; v.ewe = ewe; v.ere = ere;
    v.ea0 = ea0; v.ee0 = ee0; v.erd0 = erd0;
    v.ea1 = ea1; v.ee1 = ee1; v.erd1 = erd1;
    return v;
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.m0_req = v.r0; bus.m0_we = v.w0; bus.m0_addr = v.a0; bus.m0_wdata = v.d0;
    bus.m1_req = v.r1; bus.m1_we = v.w1; bus.m1_addr = v.a1; bus.m1_wdata = v.d1;
  endtask

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 32'd0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'd0; bus.m1_wdata = '0;
  endtask

  // One access on one port; entered and left at a falling edge
  task automatic single(input logic port, input logic we, input logic [31:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd_exp,
                        input logic err_exp);
    logic got = 1'b0;
    if (!port) begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wd;
    end else begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wd;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (port ? bus.m1_ack : bus.m0_ack) got = 1'b1;
    end
    chk("single ack seen", word_t'(got), word_t'(1'b1));
    if (got) begin
      if (we)
        chk("single write err", word_t'(port ? bus.m1_err : bus.m0_err), word_t'(err_exp));
      else
        chk("single read err/rdata",
            word_t'({port ? bus.m1_err : bus.m0_err, port ? bus.m1_rdata : bus.m0_rdata}),
            word_t'({err_exp, rd_exp}));
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] c = '0;
    int   acks;
    int   last_cyc;
    logic exp_port;

    // Segment A: m0 write then read of addr 5
    tbl.push_back(mk(1,1,5,D, 0,0,0,0, 2'b01,1,0, 0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,5,D, 0,0,0,0, 2'b01,0,0, 1,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'b00,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mk(1,0,5,0, 0,0,0,0, 2'b01,0,1, 0,0,0, 0,0,0));
    tbl.push_back(mk(1,0,5,0, 0,0,0,0, 2'b01,0,0, 1,0,D, 0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'b00,0,0, 0,0,D, 0,0,0));
    // Segment B: m1 reads 5, then out-of-range 0x400
    tbl.push_back(mk(0,0,0,0, 1,0,5,0,      2'b10,0,1, 0,0,D, 0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,5,0,      2'b10,0,0, 0,0,D, 1,0,D));
    tbl.push_back(mk(0,0,0,0, 1,0,32'h400,0, 2'b00,0,0, 0,0,D, 0,0,D));
    tbl.push_back(mk(0,0,0,0, 1,0,32'h400,0, 2'b10,0,0, 0,0,D, 0,0,D));
    tbl.push_back(mk(0,0,0,0, 1,0,32'h400,0, 2'b10,0,0, 0,0,D, 1,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,      2'b00,0,0, 0,0,D, 0,0,0));
    // Segment C: m1 back-to-back writes addr k <- k+1, req held into IDLE
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(mk(0,0,0,0, 1,1,k,k+1, 2'b10,1,0, 0,0,D, 0,0,0));
      tbl.push_back(mk(0,0,0,0, 1,1,k,k+1, 2'b10,0,0, 0,0,D, 1,0,0));
      if (k < 3)
        tbl.push_back(mk(0,0,0,0, 1,1,k+1,k+2, 2'b00,0,0, 0,0,D, 0,0,0));
      else
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,     2'b00,0,0, 0,0,D, 0,0,0));
    end

    reset = 1'b0;
    idle_inputs();
    @(negedge clk); @(negedge clk);
    chk("reset state",
        word_t'({bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.m1_ack, bus.m1_err, bus.m1_rdata,
                 bus.grant, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata}),
        word_t'(0));
    reset = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      chk($sformatf("vec %0d", i),
          word_t'({bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.m1_ack, bus.m1_err, bus.m1_rdata,
                   bus.grant, bus.mem_we, bus.mem_re}),
          word_t'({tbl[i].ea0, tbl[i].ee0, tbl[i].erd0, tbl[i].ea1, tbl[i].ee1, tbl[i].erd1,
                   tbl[i].eg, tbl[i].ewe, tbl[i].ere}));
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      c = DW'(k + 1);
      chk($sformatf("dmem[%0d]", k), word_t'(dmem[k]), word_t'(c));
    end
    chk("dmem[5]", word_t'(dmem[5]), word_t'(D));

    // Contention from reset: both hold reads, expect m0,m1,m0,m1 three cycles apart
    reset = 1'b0;
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'd2;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'd3;
    reset = 1'b1;
    acks = 0; last_cyc = -2; exp_port = 1'b0;
    for (int cyc = 0; cyc < 40 && acks < 4; cyc++) begin
      @(posedge clk); #1;
      chk("no dual ack", word_t'(bus.m0_ack & bus.m1_ack), word_t'(0));
      if (bus.m0_ack | bus.m1_ack) begin
        chk($sformatf("contention ack %0d port/rdata", acks),
            word_t'({bus.m1_ack, bus.m1_ack ? bus.m1_rdata : bus.m0_rdata}),
            word_t'({exp_port, exp_port ? 32'd4 : 32'd3}));
        chk($sformatf("contention ack %0d cycle", acks),
            word_t'(cyc), word_t'(last_cyc + 3));
        last_cyc = cyc;
        exp_port = ~exp_port;
        acks++;
      end
    end
    chk("contention ack count", word_t'(acks), word_t'(4));
    @(negedge clk);
    idle_inputs();
    @(negedge clk); @(negedge clk);

    // Reset during a write: addr 7 must keep its prior contents
    single(1'b0, 1'b1, 32'd7, 32'hA5A50007, '0, 1'b0);
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'd7; bus.m0_wdata = 32'h12345678;
    @(posedge clk); #1;
    chk("abort: mem_we in ACCESS", word_t'({bus.mem_we, bus.grant}), word_t'({1'b1, 2'b01}));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort: outputs forced by reset",
        word_t'({bus.mem_we, bus.mem_re, bus.grant, bus.m0_ack, bus.mem_addr}), word_t'(0));
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort: no ack", word_t'({bus.m0_ack, bus.m1_ack}), word_t'(0));
    end
    chk("abort: dmem[7] intact", word_t'(dmem[7]), word_t'(32'hA5A50007));
    @(negedge clk);
    single(1'b0, 1'b0, 32'd7, '0, 32'hA5A50007, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port round-robin arbiter and access sequencer in front of the single-port data memory `dm`. It lets two requesters share one word-addressed memory: the CPU data port on m0 and a loader/debug port on m1. It serialises their accesses through a three-state FSM, drives the memory's `addr`/`data_in`/`MemWrite`/`MemRead` pins, and returns registered read data with a one-cycle acknowledge. It also rejects addresses outside the memory depth.

## Interface
- `AW`, default 10: memory word-address width (depth = 2^AW words).
- `DW`, default 32: data width.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_req`  in  1  requester 0 access request; held until `m0_ack`.
- `m0_we`  in  1  1 = write, 0 = read.
- `m0_addr`  in  32  word address.
- `m0_wdata`  in  DW  write data.
- `m0_ack`  out  1  one-cycle completion pulse.
- `m0_err`  out  1  valid with `m0_ack`; 1 = address out of range.
- `m0_rdata`  out  DW  read data, valid with `m0_ack`.
- `m1_*`: identical set for requester 1.
- `mem_addr`  out  32  to dm `addr`.
- `mem_wdata`  out  DW  to dm `data_in`.
- `mem_we`  out  1  to dm `MemWrite`.
- `mem_re`  out  1  to dm `MemRead`.
- `mem_rdata`  in  DW  from dm `data_out` (combinational read).
- `grant`  out  2  one-hot owner of the current access; 00 when idle.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Requests present: pick a winner, latch its we/addr/wdata into internal registers, set `grant`, go to ACCESS.
- Arbitration:
  - Only one request: that requester wins.
  - Both request: the requester not granted last wins.
  - The last-grant pointer resets to 1, so m0 wins the first tie.
  - The pointer updates only on a grant.
- ACCESS (exactly one cycle):
  - `mem_addr`/`mem_wdata` carry the latched request.
  - In range (addr[31:AW] == 0):
    - Write: `mem_we` = 1; dm writes at the closing edge.
    - Read: `mem_re` = 1; `mem_rdata` is captured into the winner's rdata register at the closing edge.
  - Out of range: `mem_we` = `mem_re` = 0, rdata register loads 0, err flag set.
  - Always goes to RESP.
- RESP (exactly one cycle):
  - Winner's `ack` = 1.
  - `err` = range flag.
  - `rdata` holds the captured read data (write: unchanged).
  - `grant` holds its value.
  - Next state IDLE; `grant` returns to 00.
- Handshake rules:
  - Requester keeps `req` and its fields stable from assertion until it samples `ack`.
  - It deasserts `req` on the same edge that samples `ack`.
  - A `req` still high in the following IDLE cycle is a new request.
- `mX_rdata` holds its last value between accesses. The non-granted requester's outputs never change.
- `mem_addr`/`mem_wdata` hold their last latched value outside ACCESS. `mem_we`/`mem_re` are 0 outside ACCESS.

## Timing
- Reset values:
  - State IDLE, pointer = 1.
  - `m0/m1_ack` = 0, `m0/m1_err` = 0, `m0/m1_rdata` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0, `mem_we` = 0, `mem_re` = 0.
  - `grant` = 00.
- Latency: `req` seen in IDLE at cycle 0 → ACCESS cycle 1 → `ack` high during cycle 2. Next grant is possible at the earliest in cycle 3 IDLE, which gives one access per 3 cycles.
- Write data is in memory after the rising edge ending ACCESS. A read issued after that ack returns the new value.
- Reset mid-operation: asserting `reset` forces all outputs to their reset values immediately (asynchronous).
  - During ACCESS: `mem_we` drops before the edge, so no write occurs.
  - No `ack` is issued for the aborted access.
- Simultaneous requests with the pointer at either value must still produce exactly one ack per RESP, never both.

## Test plan
- Write then read, m0 only:
  - m0 writes 0xDEADBEEF to addr 5 → `mem_we` = 1 for one cycle, `m0_ack` 2 cycles after req, `m0_err` = 0.
  - m0 then reads addr 5 → `m0_rdata` = 0xDEADBEEF with `m0_ack`.
- Contention: m0 and m1 both hold reads from reset → grant order m0, m1, m0, m1. Acks 3 cycles apart. Each rdata matches its own address.
- Range check: m1 reads addr 0x400 (AW = 10) → `mem_re` stays 0, `m1_ack` = 1 with `m1_err` = 1 and `m1_rdata` = 0. Memory contents unchanged.
- Reset during write: m0 write 0x12345678 to addr 7, `reset` low in the ACCESS cycle → `mem_we` falls immediately, no ack. After release, a read of addr 7 returns its prior value.
- Back-to-back, single master: m1 issues 4 writes (addr 0–3, data 1–4) dropping `req` only at each ack → exactly 4 acks, 3 cycles apart. DMem[0..3] = 1, 2, 3, 4, and `grant` is 00 in each IDLE cycle.
